// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like responder: size codes, response
// queue entry layout and the stall LFSR seed/taps.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [2:0]  cnt;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response queue: each accepted request waits for its down-counter to
// reach zero before it may be answered from the head.
module sram_like_resp_queue
  import sram_like_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] push_rdata,
  input  logic        pop_allow,
  output logic        full,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  resp_entry_t     ent_q [OUTSTANDING];
  resp_entry_t     ent_d [OUTSTANDING];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  resp_entry_t     head_s;

  // Next-state for entries, pointers and count; head answer decode.
  always_comb begin
    ent_d   = ent_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    head_s  = ent_q[rptr_q];
    full    = (count_q == CW'(OUTSTANDING));
    data_ok = ~reset & (count_q != CW'(0)) & (head_s.cnt == 3'd0) & pop_allow;
    rdata   = (data_ok && !head_s.wr) ? head_s.rdata : 32'd0;

    if (reset) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_d[i] = '0;
      end
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      // A stalled head simply sits at zero; order is never disturbed.
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (ent_q[i].cnt != 3'd0) begin
          ent_d[i].cnt = ent_q[i].cnt - 3'd1;
        end else begin
          ent_d[i].cnt = ent_q[i].cnt;
        end
      end
      if (push) begin
        ent_d[wptr_q] = '{wr: push_wr, rdata: push_rdata, cnt: CNT_INIT};
        wptr_d        = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (data_ok) begin
        rptr_d = rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push, data_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    ent_q   <= ent_d;
    rptr_q  <= rptr_d;
    wptr_q  <= wptr_d;
    count_q <= count_d;
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like slave: word memory with byte-lane writes and fixed-latency in-order
// responses. Optional random stalls via macro SRAM_LIKE_RAND_STALL_EN.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [31:0]           mem_word_s;
  logic [31:0]           wr_word_d;
  logic [31:0]           push_rdata_s;
  logic                  mem_we_s;
  logic                  hs_s;
  logic                  full_s;
  logic                  rst_dly_q, rst_dly_d;
  logic                  stall_acc_s;
  logic                  pop_allow_s;
  logic                  unused_s;

  // Size is informational and the out-of-range address bits alias.
  assign unused_s = ^{size, addr[1:0], addr[31:DEPTH_LOG2+2]};

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Stall pattern generator, free-running outside reset.
  always_comb begin
    if (reset) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = lfsr_next(lfsr_q);
    end
    stall_acc_s = lfsr_q[0];
    pop_allow_s = ~lfsr_q[1];
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end
`else
  assign stall_acc_s = 1'b0;
  assign pop_allow_s = 1'b1;
`endif

  // Handshake, byte-lane merge and read sampling. addr_ok stays low for the
  // cycle following reset as well.
  always_comb begin
    idx_s      = addr[DEPTH_LOG2+1:2];
    mem_word_s = mem_q[idx_s];
    rst_dly_d  = reset;
    addr_ok    = ~reset & ~rst_dly_q & ~full_s & ~stall_acc_s;
    hs_s       = req & addr_ok;
    mem_we_s   = hs_s & wr;
    wr_word_d  = mem_word_s;
    for (int b = 0; b < 4; b++) begin
      wr_word_d[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : mem_word_s[8*b +: 8];
    end
    push_rdata_s = wr ? 32'd0 : mem_word_s;
  end

  // Reset-follower flop.
  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
  end

  // Memory array; intentionally not reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wr_word_d;
    end
  end

  sram_like_resp_queue #(
    .OUTSTANDING (OUTSTANDING),
    .LATENCY     (LATENCY)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (hs_s),
    .push_wr    (wr),
    .push_rdata (push_rdata_s),
    .pop_allow  (pop_allow_s),
    .full       (full_s),
    .data_ok    (data_ok),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: two instances (latency 2 and latency 5) checked
// every cycle against a queue-based reference plus hand-computed pins.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_v   [2];
  logic        wr_v    [2];
  logic [1:0]  size_v  [2];
  logic [3:0]  strb_v  [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        aok_v   [2];
  logic        dok_v   [2];
  logic [31:0] rdata_v [2];

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  bit rst_prev = 1'b1;
  int lat_c [2] = '{2, 5};

  typedef struct {
    int          inst;
    int          due;
    bit          wr;
    bit          known;
    logic [31:0] d;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] mdl_mem   [2][1024];
  bit          mdl_known [2][1024];

  always #5 clk = ~clk;

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(2), .OUTSTANDING(4)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]),
    .wstrb(strb_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .addr_ok(aok_v[0]), .data_ok(dok_v[0]), .rdata(rdata_v[0]));

  sram_like_responder #(.DEPTH_LOG2(10), .LATENCY(5), .OUTSTANDING(4)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]),
    .wstrb(strb_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .addr_ok(aok_v[1]), .data_ok(dok_v[1]), .rdata(rdata_v[1]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic fail_now(string name);
    n_chk++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  // Reference: a request seen with req high while addr_ok is expected is
  // answered LATENCY cycles later, in order; reset drops everything pending.
  always @(negedge clk) begin : model
    int          head;
    int          n;
    int          idx;
    bit          e_aok;
    bit          e_dok;
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      head = -1;
      n    = 0;
      foreach (expq[j]) begin
        if (expq[j].inst == i) begin
          n++;
          if (head < 0) head = j;
        end
      end
      e_aok = !reset && !rst_prev && (n < 4);
      e_dok = 1'b0;
      if (!reset && head >= 0) e_dok = (expq[head].due == cyc);
      chk($sformatf("addr_ok[%0d]", i), 32'(aok_v[i]), 32'(e_aok));
      chk($sformatf("data_ok[%0d]", i), 32'(dok_v[i]), 32'(e_dok));
      if (!e_dok || expq[head].wr) chk($sformatf("rdata_idle[%0d]", i), rdata_v[i], 32'd0);
      else if (expq[head].known) chk($sformatf("rdata[%0d]", i), rdata_v[i], expq[head].d);
      if (reset) begin
        for (int j = expq.size() - 1; j >= 0; j--) begin
          if (expq[j].inst == i) expq.delete(j);
        end
      end else begin
        if (e_dok) expq.delete(head);
        if (e_aok && req_v[i]) begin
          idx = int'(addr_v[i][11:2]);
          if (wr_v[i]) begin
            w = mdl_mem[i][idx];
            for (int b = 0; b < 4; b++) if (strb_v[i][b]) w[8*b +: 8] = wdata_v[i][8*b +: 8];
            mdl_mem[i][idx] = w;
            if (strb_v[i] == 4'hF) mdl_known[i][idx] = 1'b1;
            expq.push_back('{i, cyc + lat_c[i], 1'b1, 1'b1, 32'd0});
          end else begin
            expq.push_back('{i, cyc + lat_c[i], 1'b0, mdl_known[i][idx], mdl_mem[i][idx]});
          end
        end
      end
    end
    rst_prev = reset;
    cyc++;
  end

  task automatic drive(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    req_v[i] = 1'b1; wr_v[i] = w; addr_v[i] = a; wdata_v[i] = d; strb_v[i] = s; size_v[i] = 2'd2;
  endtask

  task automatic idle(int i);
    req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = 32'd0; wdata_v[i] = 32'd0;
    strb_v[i] = 4'd0; size_v[i] = 2'd0;
  endtask

  // Present one request and hold it until the handshake edge has passed.
  task automatic issue(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bit got = 1'b0;
    @(posedge clk); #1;
    drive(i, w, a, d, s);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = aok_v[i];
    end
    if (!got) fail_now("issue_handshake");
    @(posedge clk); #1;
    idle(i);
  endtask

  task automatic await(int i, output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = 32'd0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (dok_v[i]) begin
        lat = k;
        rd  = rdata_v[i];
      end
    end
    if (lat < 0) fail_now("await_data_ok");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    int          lat;
    int          acc;
    int          dcnt;
    logic [7:0]  apat;
    logic [7:0]  dpat;
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); chk("aok_first_cycle_after_reset", 32'(aok_v[0]), 32'd0);
    @(negedge clk); chk("aok_second_cycle_after_reset", 32'(aok_v[0]), 32'd1);

    // Write then read back with latency 2.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); await(0, rd, lat);
    chk("wr_latency", lat, 32'd2); chk("wr_resp_rdata", rd, 32'd0);
    issue(0, 1'b0, 32'h10, 32'd0, 4'h0); await(0, rd, lat);
    chk("rd_latency", lat, 32'd2); chk("rd_data_deadbeef", rd, 32'hDEADBEEF);

    // Partial byte-lane merge.
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF); await(0, rd, lat);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); await(0, rd, lat);
    issue(0, 1'b0, 32'h20, 32'd0, 4'h0); await(0, rd, lat);
    chk("rd_lane_merge", rd, 32'h11BB33DD);

    // Address aliasing, ignored low bits, and zero-strobe write.
    issue(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF); await(0, rd, lat);
    issue(0, 1'b0, 32'h1004, 32'd0, 4'h0); await(0, rd, lat);
    chk("rd_alias_1004", rd, 32'hCAFEF00D);
    issue(0, 1'b0, 32'h1007, 32'd0, 4'h0); await(0, rd, lat);
    chk("rd_alias_1007", rd, 32'hCAFEF00D);
    issue(0, 1'b1, 32'h4, 32'h0, 4'h0); await(0, rd, lat);
    chk("wstrb0_latency", lat, 32'd2);
    issue(0, 1'b0, 32'h4, 32'd0, 4'h0); await(0, rd, lat);
    chk("wstrb0_noop", rd, 32'hCAFEF00D);

    // Preload words used below.
    for (int k = 0; k < 16; k++) begin
      issue(0, 1'b1, 32'h100 + 32'(4 * k), 32'hA5000000 + 32'(k * 32'h10101), 4'hF);
      await(0, rd, lat);
    end
    for (int k = 0; k < 6; k++) begin
      issue(1, 1'b1, 32'h200 + 32'(4 * k), 32'h50000000 + 32'(k), 4'hF);
      await(1, rd, lat);
    end
    chk("lat5_wr_latency", lat, 32'd5);

    // Back-to-back reads into the latency-5 instance until full.
    acc = 0; dcnt = 0; apat = 8'd0; dpat = 8'd0;
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h200, 32'd0, 4'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 8) begin
        apat[k] = aok_v[1];
        dpat[k] = dok_v[1];
      end
      if (dok_v[1]) dcnt++;
      if (aok_v[1] && req_v[1]) acc++;
      @(posedge clk); #1;
      if (acc >= 6) idle(1);
      else drive(1, 1'b0, 32'h200 + 32'(4 * acc), 32'd0, 4'h0);
    end
    chk("full_addr_ok_pattern", apat, 8'hCF);
    chk("full_data_ok_pattern", dpat, 8'hE0);
    chk("full_resp_count", dcnt, 32'd6);

    // Reset with three reads pending.
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h200, 32'd0, 4'h0);
    @(posedge clk); #1; drive(1, 1'b0, 32'h204, 32'd0, 4'h0);
    @(posedge clk); #1; drive(1, 1'b0, 32'h208, 32'd0, 4'h0);
    @(posedge clk); #1; idle(1); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dcnt = 0;
    @(negedge clk); chk("aok1_first_after_reset", 32'(aok_v[1]), 32'd0);
    if (dok_v[0] || dok_v[1]) dcnt++;
    @(negedge clk); chk("aok1_second_after_reset", 32'(aok_v[1]), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (dok_v[0] || dok_v[1]) dcnt++;
      @(negedge clk);
    end
    chk("no_resp_after_reset", dcnt, 32'd0);
    issue(0, 1'b0, 32'h10, 32'd0, 4'h0); await(0, rd, lat);
    chk("mem_kept_over_reset0", rd, 32'hDEADBEEF);
    issue(1, 1'b0, 32'h208, 32'd0, 4'h0); await(1, rd, lat);
    chk("mem_kept_over_reset1", rd, 32'h50000002);

    // Random traffic on both instances, checked by the reference.
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) != 0)
        drive(0, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)),
              $urandom, 4'($urandom_range(0, 15)));
      else idle(0);
      if ($urandom_range(0, 3) != 0)
        drive(1, 1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 5)),
              $urandom, 4'($urandom_range(0, 15)));
      else idle(1);
    end
    @(posedge clk); #1;
    idle(0);
    idle(1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("model_drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
